// File: rtl/bpred_pkg.sv
// Shared types and helpers for the tournament branch predictor.
package bpred_pkg;

  typedef logic [1:0] cntT;

  localparam cntT SNT     = 2'b00;
  localparam cntT WNT     = 2'b01;
  localparam cntT WT      = 2'b10;
  localparam cntT ST      = 2'b11;
  localparam cntT CNT_RST = WNT;

  // Metadata index fields are sized for the widest legal table.
  localparam int unsigned MAX_IDX_W = 14;

  typedef struct packed {
    logic                 valid;
    logic [31:0]          pc;
    logic [MAX_IDX_W-1:0] li;
    logic [MAX_IDX_W-1:0] gi;
    logic [MAX_IDX_W-1:0] ci;
    logic                 pLoc;
    logic                 pGsh;
    logic                 pred;
  } bpMetaT;

  function automatic cntT sat_step(input cntT cnt, input logic dir);
    cntT nxt;
    if (dir) nxt = (cnt == ST)  ? ST  : cntT'(cnt + 2'd1);
    else     nxt = (cnt == SNT) ? SNT : cntT'(cnt - 2'd1);
    return nxt;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Table of 2-bit saturating counters: one async read port and one
// read-modify-write step port; every entry resets to weakly not taken.
module bp_counter_table #(
  parameter int unsigned IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rdIdx,
  output logic [1:0]       rdCnt,
  input  logic             wrEn,
  input  logic [IDX_W-1:0] wrIdx,
  input  logic             wrDir
);
  import bpred_pkg::*;

  localparam int unsigned DEPTH = 1 << IDX_W;

  cntT mem [DEPTH];

  assign rdCnt = mem[rdIdx];

  // The step reads the entry at the write index, so a lookup of the same
  // entry in this cycle still sees the pre-update value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[IDX_W'(i)] <= CNT_RST;
    end else if (wrEn) begin
      mem[wrIdx] <= sat_step(mem[wrIdx], wrDir);
    end
  end

endmodule

// File: rtl/tournament_bpred.sv
// Tournament (local / gshare / chooser) branch predictor with F->D->E->M
// metadata pipe and commit-time training. Optional counters: BP_STATS_EN.
module tournament_bpred #(
  parameter int unsigned PHT_IDX_W = 10,
  parameter int unsigned CHS_IDX_W = 10,
  parameter int unsigned GHR_W     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        stall_e,
  input  logic        flush_e,
  input  logic        flush_m,
  input  logic        branch_d,
  input  logic        branch_m,
  input  logic        actual_take_m,
  output logic        predict_f,
  output logic        predict_d,
  output logic        mispredict_m,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);
  import bpred_pkg::*;

  logic [GHR_W-1:0]     ghr;
  logic [PHT_IDX_W-1:0] liF;
  logic [PHT_IDX_W-1:0] giF;
  logic [CHS_IDX_W-1:0] ciF;
  logic [1:0]           lCnt;
  logic [1:0]           gCnt;
  logic [1:0]           cCnt;
  bpMetaT               metaF;
  bpMetaT               metaD;
  bpMetaT               metaE;
  bpMetaT               metaM;
  logic                 enD;
  logic                 trainEn;
  logic                 chsEn;
  logic                 chsDir;
  logic                 unusedBits;

  assign liF = pc_f[PHT_IDX_W+1:2];
  assign giF = liF ^ PHT_IDX_W'(ghr);
  assign ciF = pc_f[CHS_IDX_W+1:2];

  bp_counter_table #(.IDX_W(PHT_IDX_W)) uLpht (
    .clk   (clk),
    .rst   (rst),
    .rdIdx (liF),
    .rdCnt (lCnt),
    .wrEn  (trainEn),
    .wrIdx (metaM.li[PHT_IDX_W-1:0]),
    .wrDir (actual_take_m)
  );

  bp_counter_table #(.IDX_W(PHT_IDX_W)) uGpht (
    .clk   (clk),
    .rst   (rst),
    .rdIdx (giF),
    .rdCnt (gCnt),
    .wrEn  (trainEn),
    .wrIdx (metaM.gi[PHT_IDX_W-1:0]),
    .wrDir (actual_take_m)
  );

  bp_counter_table #(.IDX_W(CHS_IDX_W)) uChs (
    .clk   (clk),
    .rst   (rst),
    .rdIdx (ciF),
    .rdCnt (cCnt),
    .wrEn  (chsEn),
    .wrIdx (metaM.ci[CHS_IDX_W-1:0]),
    .wrDir (chsDir)
  );

  // Lookup record for the instruction currently in F.
  always_comb begin
    metaF       = '0;
    metaF.valid = 1'b1;
    metaF.pc    = pc_f;
    metaF.li    = MAX_IDX_W'(liF);
    metaF.gi    = MAX_IDX_W'(giF);
    metaF.ci    = MAX_IDX_W'(ciF);
    metaF.pLoc  = lCnt[1];
    metaF.pGsh  = gCnt[1];
    metaF.pred  = cCnt[1] ? gCnt[1] : lCnt[1];
  end

  assign predict_f = metaF.pred;
  assign predict_d = metaD.pred & branch_d;
  assign enD       = ~stall_d & ~stall_e;

  // While a stage is held, the stage behind it receives a bubble rather
  // than a second copy, so every branch reaches M exactly once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      metaD <= '0;
      metaE <= '0;
      metaM <= '0;
    end else begin
      if (flush_d)  metaD.valid <= 1'b0;
      else if (enD) metaD       <= metaF;

      if (flush_e) begin
        metaE.valid <= 1'b0;
      end else if (!stall_e) begin
        metaE       <= metaD;
        metaE.valid <= metaD.valid & branch_d & ~stall_d;
      end

      metaM       <= metaE;
      metaM.valid <= metaE.valid & ~flush_m & ~stall_e;
    end
  end

  assign trainEn      = branch_m & metaM.valid;
  assign mispredict_m = trainEn & (metaM.pred != actual_take_m);
  // Chooser moves only when exactly one component was right.
  assign chsEn        = trainEn & (metaM.pLoc != metaM.pGsh);
  assign chsDir       = (metaM.pGsh == actual_take_m);

  // Committed history: shift in the resolved direction at training edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ghr <= '0;
    else if (trainEn) ghr <= GHR_W'({ghr, actual_take_m});
  end

`ifdef BP_STATS_EN
  logic [31:0] brCnt;
  logic [31:0] misCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brCnt  <= '0;
      misCnt <= '0;
    end else if (trainEn) begin
      if (brCnt != 32'hFFFF_FFFF) brCnt <= brCnt + 32'd1;
      if (mispredict_m && misCnt != 32'hFFFF_FFFF) misCnt <= misCnt + 32'd1;
    end
  end

  assign stat_branches    = brCnt;
  assign stat_mispredicts = misCnt;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

  // Carried-but-unconsumed metadata bits and counter LSBs at lookup.
  assign unusedBits = ^{metaM, lCnt[0], gCnt[0], cCnt[0]};

endmodule
